// File: rtl/dscnn_pkg.sv
// Shared types and default sizing for the DS-CNN accelerator blocks.
package dscnn_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_CH   = 24;
    localparam int DEF_N_LAYERS = 10;

    typedef enum logic [1:0] {EMPTY, LOAD, READY, STREAM} bias_state_e;

    typedef logic signed [DEF_DATA_W-1:0] bias_t;
endpackage

// File: rtl/bias_regfile.sv
// 1W/1R bias storage with a registered read port; contents are never reset.
// The read register only updates on rd_en, so it doubles as the held output word.
module bias_regfile #(
    parameter  int DEPTH   = 240,
    parameter  int ENTRY_W = 32,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/bias_stream_buf.sv
// Loadable bias store streaming one layer's per-channel biases under valid/ready.
// Define BIAS_PARITY_EN to store an even-parity bit per entry and flag read errors.
module bias_stream_buf
    import dscnn_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int MAX_CH   = DEF_MAX_CH,
    parameter  int N_LAYERS = DEF_N_LAYERS,
    localparam int DEPTH    = N_LAYERS * MAX_CH,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int LAYER_W  = $clog2(N_LAYERS),
    localparam int CNT_W    = $clog2(MAX_CH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic                     wr_valid,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic                     load_done,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [LAYER_W-1:0]       req_layer,
    input  logic [CNT_W-1:0]         req_count,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     parity_err
);
    // Stream addresses are wide enough for any req_layer so out-of-range slots are detectable.
    localparam int SA_W = LAYER_W + CNT_W;
`ifdef BIAS_PARITY_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    bias_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [SA_W-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               oor_q, oor_d;

    logic               rf_wr_en, rf_rd_en;
    logic [ADDR_W-1:0]  rf_rd_addr;
    logic [ENTRY_W-1:0] rf_wdata, rf_rdata;
    logic [CNT_W-1:0]   req_cnt_c;
    logic [SA_W-1:0]    req_base, nxt_addr;
    logic               base_oor, nxt_oor;

    assign req_cnt_c = (req_count > CNT_W'(MAX_CH)) ? CNT_W'(MAX_CH) : req_count;
    assign req_base  = SA_W'(req_layer) * SA_W'(MAX_CH);
    assign nxt_addr  = addr_q + SA_W'(1);
    assign base_oor  = req_base >= SA_W'(DEPTH);
    assign nxt_oor   = nxt_addr >= SA_W'(DEPTH);

    // A reload request in READY takes priority, so no request is accepted that cycle.
    assign req_ready = (state_q == READY) && !load_start;
    assign load_done = (state_q == READY) || (state_q == STREAM);

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        oor_d       = oor_q;
        rf_wr_en    = 1'b0;
        rf_rd_en    = 1'b0;
        rf_rd_addr  = ADDR_W'(req_base);
        case (state_q)
            EMPTY: begin
                if (load_start) begin
                    state_d  = LOAD;
                    wr_cnt_d = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    wr_cnt_d = '0;
                end else if (wr_valid) begin
                    rf_wr_en = 1'b1;
                    wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                    if (wr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_d  = READY;
                        wr_cnt_d = '0;
                    end
                end
            end
            READY: begin
                if (load_start) begin
                    state_d  = LOAD;
                    wr_cnt_d = '0;
                end else if (req_valid && req_cnt_c != '0) begin
                    state_d     = STREAM;
                    out_valid_d = 1'b1;
                    out_last_d  = (req_cnt_c == CNT_W'(1));
                    addr_d      = req_base;
                    rem_d       = req_cnt_c;
                    oor_d       = base_oor;
                    rf_rd_en    = !base_oor;
                end
            end
            STREAM: begin
                // Stalled words keep rf_rd_en low, which freezes the read register.
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = READY;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        oor_d       = 1'b0;
                    end else begin
                        addr_d     = nxt_addr;
                        rem_d      = rem_q - CNT_W'(1);
                        out_last_d = (rem_q == CNT_W'(2));
                        oor_d      = nxt_oor;
                        rf_rd_en   = !nxt_oor;
                        rf_rd_addr = ADDR_W'(nxt_addr);
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            wr_cnt_q    <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            oor_q       <= oor_d;
        end
    end

    bias_regfile #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_rf (
        .clk     (clk),
        .wr_en   (rf_wr_en),
        .wr_addr (wr_cnt_q),
        .wr_data (rf_wdata),
        .rd_en   (rf_rd_en),
        .rd_addr (rf_rd_addr),
        .rd_data (rf_rdata)
    );

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = (out_valid_q && !oor_q) ? rf_rdata[DATA_W-1:0] : '0;

`ifdef BIAS_PARITY_EN
    logic perr_q, perr_d;

    assign rf_wdata = {^wr_data, wr_data};

    // Stored bit makes the whole entry even; any odd entry read back is corrupt.
    always_comb begin
        perr_d = perr_q;
        if (load_start && state_q != STREAM)
            perr_d = 1'b0;
        else if (out_valid_q && !oor_q && (^rf_rdata))
            perr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_q <= 1'b0;
        else        perr_q <= perr_d;
    end

    assign parity_err = perr_q;
`else
    assign rf_wdata   = wr_data;
    assign parity_err = 1'b0;
`endif
endmodule
